// File: rtl/systolic_feeder.sv
// Skews A column slices and B row slices into a systolic array edge; lane i is
// delayed by i+1 cycles, idle slots carry +0.0, and a flush drains the array.
module systolic_feeder #(
    parameter int unsigned N           = 4,
    parameter int unsigned W           = 32,
    parameter int unsigned FLUSH_EXTRA = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_a,
    input  logic [N*W-1:0]   in_b,
    input  logic             in_last,
    output logic [N*W-1:0]   a_out,
    output logic [N*W-1:0]   b_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      k_count
);

    localparam int unsigned FLUSH_LEN = N - 1 + FLUSH_EXTRA;
    localparam int unsigned CW        = 9;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] flush_cnt;
    logic          accept;

    assign accept = in_valid && in_ready;

    // Product sequencing; done is raised on the edge that enters the last FLUSH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            k_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (state == IDLE) begin
                            k_count <= 16'd1;
                        end else if (k_count != 16'hFFFF) begin
                            k_count <= k_count + 16'd1;
                        end
                        if (in_last) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                            in_ready  <= 1'b0;
                            done      <= (FLUSH_LEN == 32'd1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == CW'(FLUSH_LEN - 1)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                        done      <= (flush_cnt == CW'(FLUSH_LEN - 2));
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane shift chains of depth i+1; the last stage drives the array edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_sr [i+1];
        logic [W-1:0] b_sr [i+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else begin
                a_sr[0] <= accept ? in_a[i*W +: W] : '0;
                b_sr[0] <= accept ? in_b[i*W +: W] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end

        assign a_out[i*W +: W] = a_sr[i];
        assign b_out[i*W +: W] = b_sr[i];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: injection history queue for lane data
// plus a small sequencing model for ready/busy/done/k_count.
module tb_systolic_feeder;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned FE = 2;
    localparam int          FL = N - 1 + FE;

    localparam logic [W-1:0] F1 = 32'h3F800000;
    localparam logic [W-1:0] F2 = 32'h40000000;
    localparam logic [W-1:0] F3 = 32'h40400000;
    localparam logic [W-1:0] F4 = 32'h40800000;
    localparam logic [W-1:0] F5 = 32'h40A00000;
    localparam logic [W-1:0] F6 = 32'h40C00000;
    localparam logic [W-1:0] F7 = 32'h40E00000;
    localparam logic [W-1:0] F8 = 32'h41000000;
    localparam logic [W-1:0] F9 = 32'h41100000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*W-1:0]   in_a = '0;
    logic [N*W-1:0]   in_b = '0;
    logic             in_last = 1'b0;
    logic [N*W-1:0]   a_out;
    logic [N*W-1:0]   b_out;
    logic             busy;
    logic             done;
    logic [15:0]      k_count;

    systolic_feeder #(.N(N), .W(W), .FLUSH_EXTRA(FE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .a_out    (a_out),
        .b_out    (b_out),
        .busy     (busy),
        .done     (done),
        .k_count  (k_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
    } inj_t;

    inj_t        hist[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_seen = 0;
    int          m_flush = 0;
    bit          m_stream = 1'b0;
    logic [15:0] m_k = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] splat(input logic [W-1:0] x);
        return {N{x}};
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cycle(input logic r, input logic v, input logic last,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        inj_t e;
        logic acc;
        rst = r; in_valid = v; in_last = last; in_a = a; in_b = b;
        @(posedge clk);
        if (r) begin
            m_flush = 0; m_stream = 1'b0; m_k = '0;
            hist.delete();
            for (int i = 0; i < N; i++) hist.push_back('0);
        end else begin
            acc = v && (m_flush == 0);
            e.a = acc ? a : '0;
            e.b = acc ? b : '0;
            hist.push_back(e);
            if (hist.size() > N) void'(hist.pop_front());
            if (m_flush > 0) begin
                m_flush--;
            end else if (acc) begin
                if (!m_stream) m_k = 16'd1;
                else if (m_k != 16'hFFFF) m_k = m_k + 16'd1;
                if (last) begin
                    m_flush  = FL;
                    m_stream = 1'b0;
                end else begin
                    m_stream = 1'b1;
                end
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("a_lane%0d", i), a_out[i*W +: W], hist[N-1-i].a[i*W +: W]);
            check($sformatf("b_lane%0d", i), b_out[i*W +: W], hist[N-1-i].b[i*W +: W]);
        end
        check("in_ready", W'(in_ready), W'(m_flush == 0));
        check("busy",     W'(busy),     W'(m_stream || m_flush > 0));
        check("done",     W'(done),     W'(m_flush == 1));
        check("k_count",  W'(k_count),  W'(m_k));
        if (done) done_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        int             low;
        bit             got;
        bit             pre;

        // Reset, then idle
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(5);
        check("idle_ready", W'(in_ready), 32'd1);
        check("idle_busy", W'(busy), 32'd0);
        check("idle_a0", a_out[0 +: W], 32'd0);
        check("idle_b3", b_out[3*W +: W], 32'd0);

        // Single-vector product
        va = {F4, F3, F2, F1};
        vb = {F1, F2, F3, F4};
        done_seen = 0;
        cycle(1'b0, 1'b1, 1'b1, va, vb);
        check("sv_lane0_c1", a_out[0 +: W], F1);
        idle(1);
        check("sv_lane1_c2", a_out[W +: W], F2);
        idle(2);
        check("sv_lane3_c4", a_out[3*W +: W], F4);
        check("sv_b3_c4", b_out[3*W +: W], F1);
        idle(6);
        check("sv_done_pulses", W'(done_seen), 32'd1);
        check("sv_idle_busy", W'(busy), 32'd0);

        // K=3 back-to-back, with the next product offered throughout FLUSH
        cycle(1'b0, 1'b1, 1'b0, splat(F1), splat(F1));
        cycle(1'b0, 1'b1, 1'b0, splat(F2), splat(F2));
        cycle(1'b0, 1'b1, 1'b1, splat(F3), splat(F3));
        check("k3_count", W'(k_count), 32'd3);
        low = 0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            if (!in_ready) low++;
            pre = (m_flush == 0);
            cycle(1'b0, 1'b1, 1'b1, splat(F5), splat(F6));
            if (pre) got = 1'b1;
        end
        check("b2b_accepted", W'(got), 32'd1);
        check("k3_ready_low", W'(low), 32'd5);
        check("b2b_lane0", a_out[0 +: W], F5);
        check("b2b_k", W'(k_count), 32'd1);
        idle(6);

        // K=2 with a bubble, plus in_last without in_valid
        cycle(1'b0, 1'b0, 1'b1, splat(F9), splat(F9));
        check("last_no_valid", W'(busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, splat(F7), splat(F7));
        check("gap_v0", a_out[0 +: W], F7);
        cycle(1'b0, 1'b0, 1'b0, splat(F9), splat(F9));
        check("gap_zero", a_out[0 +: W], 32'd0);
        cycle(1'b0, 1'b1, 1'b1, splat(F8), splat(F8));
        check("gap_v1", a_out[0 +: W], F8);
        idle(7);

        // Reset during the third FLUSH cycle
        done_seen = 0;
        cycle(1'b0, 1'b1, 1'b0, splat(F1), splat(F2));
        cycle(1'b0, 1'b1, 1'b1, splat(F3), splat(F4));
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, splat(F9), splat(F9));
        check("rst_a3", a_out[3*W +: W], 32'd0);
        check("rst_busy", W'(busy), 32'd0);
        check("rst_ready", W'(in_ready), 32'd1);
        idle(8);
        check("rst_no_done", W'(done_seen), 32'd0);

        // Reset wins over a simultaneous accept
        cycle(1'b1, 1'b1, 1'b1, splat(F9), splat(F9));
        check("rst_prio_k", W'(k_count), 32'd0);
        idle(2);
        check("rst_prio_a1", a_out[W +: W], 32'd0);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                va[i*W +: W] = W'($urandom());
                vb[i*W +: W] = W'($urandom());
            end
            cycle(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), va, vb);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
